// File: rtl/regfile_pkg.sv
// Shared types and defaults for the riscv32i multi-port register file.
// Consumers: regfile_mp, regfile_scoreboard, decode and hazard units.
package regfile_pkg;

  localparam int RF_XLEN  = 32;
  localparam int RF_NREGS = 32;

  typedef enum logic {RF_CLEAR, RF_READY} rf_state_e;

  function automatic int rf_aw(input int nregs);
    return $clog2(nregs);
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending-write scoreboard: an issue sets a bit, a writeback clears it.
// When both target the same register in one cycle, the set wins. Bit 0 is always 0.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int  NREGS = RF_NREGS,
  localparam int AW    = rf_aw(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             set_en,
  input  logic [AW-1:0]    set_addr,
  input  logic             clr_en,
  input  logic [AW-1:0]    clr_addr,
  output logic [NREGS-1:0] busy_vec
);

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    busy_d = busy_q;
    if (clr_en) busy_d[clr_addr] = 1'b0;
    if (set_en) busy_d[set_addr] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  assign busy_vec = busy_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port integer register file with registered reads, a post-reset clear
// sequencer and a pending-write scoreboard. Define REGFILE_BYPASS_EN for write-through forwarding.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int  XLEN  = RF_XLEN,
  parameter int  NREGS = RF_NREGS,
  parameter int  NRD   = 2,
  localparam int AW    = rf_aw(NREGS)
) (
  input  logic                      clk,
  input  logic                      rst,
  output logic                      ready,
  input  logic                      we,
  input  logic [AW-1:0]             wa,
  input  logic [XLEN-1:0]           wd,
  input  logic [NRD-1:0][AW-1:0]    ra,
  output logic [NRD-1:0][XLEN-1:0]  rd,
  output logic [NRD-1:0]            rbusy,
  input  logic                      iss_valid,
  input  logic [AW-1:0]             iss_addr,
  output logic [NREGS-1:0]          busy_vec
);

  rf_state_e              state;
  logic [AW-1:0]          clr_idx;
  logic [XLEN-1:0]        mem [NREGS];
  logic                   is_ready;
  logic                   wr_en;
  logic                   iss_en;
  logic [NRD-1:0][XLEN-1:0] rd_d;
  logic [NRD-1:0]         rbusy_d;

  assign is_ready = (state == RF_READY);
  assign wr_en    = is_ready && we && (wa != '0);
  assign iss_en   = is_ready && iss_valid && (iss_addr != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= RF_CLEAR;
      clr_idx <= '0;
      ready   <= 1'b0;
    end else if (state == RF_CLEAR) begin
      clr_idx <= clr_idx + 1'b1;
      if (clr_idx == AW'(NREGS - 1)) begin
        state <= RF_READY;
        ready <= 1'b1;
      end
    end
  end

  // NOTE: the storage array has no reset; the clear sequencer zeroes it after every reset.
  always_ff @(posedge clk) begin
    if (state == RF_CLEAR) mem[clr_idx] <= '0;
    else if (wr_en)        mem[wa]      <= wd;
  end

  regfile_scoreboard #(.NREGS(NREGS)) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .set_en   (iss_en),
    .set_addr (iss_addr),
    .clr_en   (wr_en),
    .clr_addr (wa),
    .busy_vec (busy_vec)
  );

  // Read ports sample pre-write storage and pre-update scoreboard state.
  always_comb begin
    rd_d    = '0;
    rbusy_d = '0;
    for (int i = 0; i < NRD; i++) begin
      rd_d[i]    = (ra[i] == '0) ? '0 : mem[ra[i]];
      rbusy_d[i] = busy_vec[ra[i]];
`ifdef REGFILE_BYPASS_EN
      if (wr_en && (wa == ra[i])) begin
        rd_d[i]    = wd;
        rbusy_d[i] = 1'b0;
      end
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd    <= '0;
      rbusy <= '0;
    end else if (is_ready) begin
      rd    <= rd_d;
      rbusy <= rbusy_d;
    end else begin
      rd    <= '0;
      rbusy <= '0;
    end
  end

endmodule
